debounce_multi: RTL and testbench



---
 rtl/debounce_multi_pkg.sv | 27 ++
 rtl/debounce_multi_channel.sv | 74 +++++++
 rtl/debounce_multi.sv | 55 +++++
 tb/tb_debounce_multi.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/debounce_multi_pkg.sv
// Shared helpers and default widths for the multi-channel debouncer.
package debounce_multi_pkg;

  localparam int DEF_N_CH        = 4;
  localparam int DEF_DIV         = 50000;
  localparam int DEF_STABLE      = 4;
  localparam int DEF_SYNC_STAGES = 2;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  // Register width able to hold n_states distinct values, never narrower than 1 bit
  // so that DIV = 1 still yields a legal (constant-zero) prescaler register.
  function automatic int cnt_width(input int n_states);
    return (clog2(n_states) < 1) ? 1 : clog2(n_states);
  endfunction

  // Widths for the default configuration; modules derive their own from their parameters.
  localparam int PCNT_W = cnt_width(DEF_DIV);
  localparam int CNT_W  = cnt_width(DEF_STABLE + 1);

endpackage

// File: rtl/debounce_multi_channel.sv
// One debounce channel: input synchroniser, stability counter, level and edge pulses.
module debounce_channel
  import debounce_multi_pkg::*;
#(
  parameter int STABLE      = DEF_STABLE,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_i,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int                  CNT_BITS = cnt_width(STABLE + 1);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(STABLE - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_sync;
  logic [CNT_BITS-1:0]    cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign s_sync = sync_q[SYNC_STAGES-1];

  // Synchroniser runs every cycle, independent of enable/tick.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
  end

  // On each tick: agreement restarts the count, STABLE disagreements flip the level.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (tick_i) begin
      if (s_sync == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        level_d = s_sync;
        rise_d  = s_sync;
        fall_d  = ~s_sync;
      end else begin
        cnt_d = cnt_q + CNT_BITS'(1);
      end
    end
  end

  // Counter, level and single-cycle pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer top: shared sample-tick prescaler plus one channel per input.
module debounce_multi
  import debounce_multi_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int DIV         = DEF_DIV,
  parameter int STABLE      = DEF_STABLE,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            tick
);

  localparam int                   PCNT_BITS = cnt_width(DIV);
  localparam logic [PCNT_BITS-1:0] PCNT_LAST = PCNT_BITS'(DIV - 1);

  logic [PCNT_BITS-1:0] pcnt_q, pcnt_d;

  assign tick = enable && (pcnt_q == PCNT_LAST);

  // Prescaler wraps at DIV-1 and holds while enable is low.
  always_comb begin
    pcnt_d = pcnt_q;
    if (tick)        pcnt_d = '0;
    else if (enable) pcnt_d = pcnt_q + PCNT_BITS'(1);
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (reset) pcnt_q <= '0;
    else       pcnt_q <= pcnt_d;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .STABLE      (STABLE),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .tick_i  (tick),
      .btn_i   (btn_in[i]),
      .level_o (btn_out[i]),
      .rise_o  (rise[i]),
      .fall_o  (fall[i])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi (N_CH=4, DIV=4, STABLE=3, SYNC_STAGES=2).
module tb_debounce_multi;

  localparam int N_CH        = 4;
  localparam int DIV         = 4;
  localparam int STABLE      = 3;
  localparam int SYNC_STAGES = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] btn_out;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic            tick;

  debounce_multi #(
    .N_CH        (N_CH),
    .DIV         (DIV),
    .STABLE      (STABLE),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .btn_in  (btn_in),
    .btn_out (btn_out),
    .rise    (rise),
    .fall    (fall),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    bit up;
    int edge_n;
  } evt_t;

  evt_t exp_q[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, cyc);
    end
  endtask

  // Called at a negedge: the next posedge is edge cyc+1; the level flip is expected d edges later.
  task automatic expect_evt(input int ch, input bit up, input int d);
    evt_t e;
    e.ch     = ch;
    e.up     = up;
    e.edge_n = cyc + 1 + d;
    exp_q.push_back(e);
  endtask

  task automatic at_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge just before a tick edge.
  task automatic align_tick();
    int k;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!tick && k < 16);
    if (!tick) begin
      n_cmp++;
      n_err++;
      $display("FAIL align_tick: no tick within %0d cycles", k);
    end
    @(negedge clk);
  endtask

  // Monitor: every pulse must match the next expected event in order.
  initial begin
    evt_t e;
    forever begin
      @(posedge clk); #1;
      for (int c = 0; c < N_CH; c++) begin
        if (rise[c] || fall[c]) begin
          check("rise_fall_exclusive", int'(rise[c] & fall[c]), 0);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_pulse: ch %0d rise %0b fall %0b at edge %0d, expected none",
                     c, rise[c], fall[c], cyc);
          end else begin
            e = exp_q.pop_front();
            check("pulse_channel", c, e.ch);
            check("pulse_direction", int'(rise[c]), int'(e.up));
            check("pulse_edge", cyc, e.edge_n);
            check("level_after_pulse", int'(btn_out[c]), int'(e.up));
          end
        end
      end
    end
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    btn_in = 4'hF;
    repeat (4) @(posedge clk);
    #1;
    check("reset_btn_out", int'(btn_out), 0);
    check("reset_rise", int'(rise), 0);
    check("reset_fall", int'(fall), 0);
    check("reset_tick", int'(tick), 0);

    @(negedge clk);
    reset  = 1'b0;
    btn_in = 4'h0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check("first_tick_phase", int'(tick), int'(k == 3));
    end

    // Clean press on ch0.
    align_tick();
    btn_in[0] = 1'b1;
    expect_evt(0, 1'b1, 12);
    at_neg(20);
    check("press_ch0_level", int'(btn_out), 4'h1);

    // Bounce on ch1: 2 ticks high, 1 tick low, five times, then hold.
    align_tick();
    for (int r = 0; r < 5; r++) begin
      btn_in[1] = 1'b1;
      at_neg(8);
      btn_in[1] = 1'b0;
      check("bounce_ch1_level", int'(btn_out[1]), 0);
      at_neg(4);
    end
    btn_in[1] = 1'b1;
    expect_evt(1, 1'b1, 12);
    at_neg(20);
    check("bounce_ch1_final", int'(btn_out), 4'h3);

    // ch2/ch3 pressed together, then released together.
    align_tick();
    btn_in[3:2] = 2'b11;
    expect_evt(2, 1'b1, 12);
    expect_evt(3, 1'b1, 12);
    at_neg(20);
    check("press_ch23_level", int'(btn_out), 4'hF);
    align_tick();
    btn_in[3:2] = 2'b00;
    expect_evt(2, 1'b0, 12);
    expect_evt(3, 1'b0, 12);
    at_neg(20);
    check("release_ch23_level", int'(btn_out), 4'h3);

    // Release ch0, then press it with an enable freeze after two counting ticks.
    align_tick();
    btn_in[0] = 1'b0;
    expect_evt(0, 1'b0, 12);
    at_neg(20);
    check("release_ch0_level", int'(btn_out), 4'h2);
    align_tick();
    btn_in[0] = 1'b1;
    expect_evt(0, 1'b1, 32);
    at_neg(12);
    enable = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      check("freeze_tick", int'(tick), 0);
      check("freeze_rise", int'(rise), 0);
    end
    check("freeze_level", int'(btn_out), 4'h2);
    @(negedge clk);
    enable = 1'b1;
    at_neg(10);
    check("unfreeze_level", int'(btn_out), 4'h3);

    // Reset while ch0 is two ticks into a release.
    align_tick();
    btn_in[0] = 1'b0;
    at_neg(9);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_btn_out", int'(btn_out), 0);
    check("midreset_fall", int'(fall), 0);
    check("midreset_rise", int'(rise), 0);
    check("midreset_tick", int'(tick), 0);
    @(negedge clk);
    reset  = 1'b0;
    btn_in = 4'h1;
    expect_evt(0, 1'b1, 11);
    at_neg(20);
    check("post_reset_level", int'(btn_out), 4'h1);

    at_neg(5);
    check("pending_events", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
